// File: rtl/alu_pkg.sv
// Opcode encodings, instruction field positions and the ALU opcode classifiers.
// Shared by the issue queue and anything else that decodes the ALU subset.
package alu_pkg;

    localparam int OP_W     = 6;
    localparam int F_OP_LSB = 26;
    localparam int F_RS_LSB = 21;
    localparam int F_RT_LSB = 16;
    localparam int F_RD_LSB = 11;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_X06   = 6'b000110;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;

    function automatic logic is_alu_rtype(input logic [OP_W-1:0] op);
        return op == OP_RTYPE;
    endfunction

    function automatic logic is_alu_itype(input logic [OP_W-1:0] op);
        case (op)
            OP_ADDI, OP_ADDIU, OP_X06, OP_SLTIU, OP_ANDI, OP_ORI,
            OP_XORI, OP_LUI, OP_SW, OP_LW: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch, scoreboard, lane back-pressure and issue bundle of the ALU issue queue.
// master = dispatch/execution side, slave = the queue itself.
interface alu_issue_queue_if #(
    parameter int DEPTH   = 16,
    parameter int ISSUE_W = 2,
    parameter int IW      = 32,
    parameter int NW      = 32,
    parameter int NREG    = 32
);
    logic                         flush;
    logic                         enq_valid;
    logic                         enq_ready;
    logic [IW-1:0]                enq_instr;
    logic [NW-1:0]                enq_instr_no;
    logic [NREG-1:0]              reg_ready;
    logic [ISSUE_W-1:0]           exu_ready;
    logic [ISSUE_W-1:0]           iss_valid;
    logic [ISSUE_W*IW-1:0]        iss_instr;
    logic [ISSUE_W*NW-1:0]        iss_instr_no;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         err_unsupported;

    modport master (
        output flush, enq_valid, enq_instr, enq_instr_no, reg_ready, exu_ready,
        input  enq_ready, iss_valid, iss_instr, iss_instr_no, count, err_unsupported
    );

    modport slave (
        input  flush, enq_valid, enq_instr, enq_instr_no, reg_ready, exu_ready,
        output enq_ready, iss_valid, iss_instr, iss_instr_no, count, err_unsupported
    );
endinterface

// File: rtl/alu_issue_select.sv
// Combinational oldest-first picker: k-th eligible lane gets the k-th oldest ready entry.
// Zero latency; a lane with exu_rdy_i low is skipped and takes nothing.
module alu_issue_select #(
    parameter int DEPTH   = 16,
    parameter int ISSUE_W = 2
) (
    input  logic [DEPTH-1:0]              ent_rdy_i,
    input  logic [ISSUE_W-1:0]            exu_rdy_i,
    output logic [ISSUE_W-1:0][DEPTH-1:0] sel_oh_o,
    output logic [ISSUE_W-1:0]            sel_vld_o
);
    always_comb begin : pick
        logic [DEPTH-1:0] avail;
        avail     = ent_rdy_i;
        sel_oh_o  = '0;
        sel_vld_o = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (exu_rdy_i[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (avail[i] && !sel_vld_o[k]) begin
                        sel_oh_o[k][i] = 1'b1;
                        sel_vld_o[k]   = 1'b1;
                        avail[i]       = 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/alu_issue_queue.sv
// Age-ordered, self-compacting ALU issue queue; issue registered 1 cycle after selection.
// enq_ready depends only on registered count; per-lane exu_ready masks issue lanes.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ISSUE_W = 2,
    parameter int IW      = 32,
    parameter int NW      = 32,
    parameter int NREG    = 32
) (
    input logic             clk,
    input logic             rst_n,
    alu_issue_queue_if.slave q
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int RW = $clog2(NREG);

    logic [IW-1:0]         instr_q [DEPTH];
    logic [IW-1:0]         instr_d [DEPTH];
    logic [NW-1:0]         no_q    [DEPTH];
    logic [NW-1:0]         no_d    [DEPTH];
    logic [CW-1:0]         count_q, count_d;
    logic                  err_q, err_d;
    logic [ISSUE_W-1:0]    iss_vld_q, iss_vld_d;
    logic [ISSUE_W*IW-1:0] iss_instr_q, iss_instr_d;
    logic [ISSUE_W*NW-1:0] iss_no_q, iss_no_d;

    logic [DEPTH-1:0]              ent_rdy;
    logic [ISSUE_W-1:0][DEPTH-1:0] sel_oh;
    logic [ISSUE_W-1:0]            sel_vld;
    logic                          enq_rdy, enq_fire, enq_supported;

    function automatic logic reg_ok(input logic [RW-1:0] r, input logic [NREG-1:0] rr);
        return (r == '0) || rr[r];
    endfunction

    assign enq_rdy       = rst_n && (count_q < CW'(DEPTH));
    assign enq_fire      = q.enq_valid && enq_rdy;
    assign enq_supported = is_alu_rtype(q.enq_instr[F_OP_LSB +: OP_W]) ||
                           is_alu_itype(q.enq_instr[F_OP_LSB +: OP_W]);

    // Only stored (hence ALU) entries reach here, so non-R-type means I-type.
    always_comb begin : operand_ready
        logic [RW-1:0]   rs, rt, rd;
        logic [OP_W-1:0] op;
        ent_rdy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            op = instr_q[i][F_OP_LSB +: OP_W];
            rs = instr_q[i][F_RS_LSB +: RW];
            rt = instr_q[i][F_RT_LSB +: RW];
            rd = instr_q[i][F_RD_LSB +: RW];
            ent_rdy[i] = (i < int'(count_q)) && reg_ok(rs, q.reg_ready) && reg_ok(rt, q.reg_ready) &&
                         (!is_alu_rtype(op) || reg_ok(rd, q.reg_ready));
        end
    end

    alu_issue_select #(.DEPTH(DEPTH), .ISSUE_W(ISSUE_W)) u_select (
        .ent_rdy_i (ent_rdy),
        .exu_rdy_i (q.exu_ready),
        .sel_oh_o  (sel_oh),
        .sel_vld_o (sel_vld)
    );

    always_comb begin : next_state
        logic [DEPTH-1:0] removed;
        logic             keep;
        int               wp;
        removed = '0;
        keep    = 1'b0;
        wp      = 0;
        instr_d = instr_q;
        no_d    = no_q;
        for (int k = 0; k < ISSUE_W; k++) removed = removed | sel_oh[k];
        // Survivors slide down over issued slots; wp never passes i, so reading _q is safe.
        for (int i = 0; i < DEPTH; i++) begin
            keep = (i < int'(count_q)) && !removed[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (keep && j == wp) begin
                    instr_d[j] = instr_q[i];
                    no_d[j]    = no_q[i];
                end
            end
            if (keep) wp = wp + 1;
        end
        if (enq_fire && enq_supported && !q.flush) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j == wp) begin
                    instr_d[j] = q.enq_instr;
                    no_d[j]    = q.enq_instr_no;
                end
            end
            wp = wp + 1;
        end
        count_d = q.flush ? '0 : CW'(wp);
        err_d   = err_q || (enq_fire && !enq_supported);

        iss_vld_d   = q.flush ? '0 : sel_vld;
        iss_instr_d = iss_instr_q;
        iss_no_d    = iss_no_q;
        for (int k = 0; k < ISSUE_W; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!q.flush && sel_oh[k][i]) begin
                    iss_instr_d[k*IW +: IW] = instr_q[i];
                    iss_no_d[k*NW +: NW]    = no_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            err_q       <= 1'b0;
            iss_vld_q   <= '0;
            iss_instr_q <= '0;
            iss_no_q    <= '0;
        end else begin
            count_q     <= count_d;
            err_q       <= err_d;
            iss_vld_q   <= iss_vld_d;
            iss_instr_q <= iss_instr_d;
            iss_no_q    <= iss_no_d;
        end
    end

    // Payload storage is qualified by count_q, so it needs no reset.
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        no_q    <= no_d;
    end

    assign q.enq_ready       = enq_rdy;
    assign q.count           = count_q;
    assign q.err_unsupported = err_q;
    assign q.iss_valid       = iss_vld_q;
    assign q.iss_instr       = iss_instr_q;
    assign q.iss_instr_no    = iss_no_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: opcode table plus hand-written multi-cycle sequences.
module tb_alu_issue_queue;
    localparam int DEPTH = 16, ISSUE_W = 2, IW = 32, NW = 32, NREG = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_queue_if #(.DEPTH(DEPTH), .ISSUE_W(ISSUE_W), .IW(IW), .NW(NW), .NREG(NREG)) qif ();

    alu_issue_queue #(.DEPTH(DEPTH), .ISSUE_W(ISSUE_W), .IW(IW), .NW(NW), .NREG(NREG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (qif)
    );

    typedef struct {
        logic [5:0] op;
        logic [4:0] exp_count;
        logic       exp_err;
    } vec_t;

    vec_t tbl [14];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'h020};
    endfunction

    function automatic logic [NW-1:0] lane_no(input int k);
        return qif.iss_instr_no[k*NW +: NW];
    endfunction

    task automatic enq(input logic [31:0] instr, input logic [31:0] no);
        qif.enq_instr    = instr;
        qif.enq_instr_no = no;
        qif.enq_valid    = 1'b1;
        step();
        qif.enq_valid    = 1'b0;
    endtask

    task automatic do_flush();
        qif.flush = 1'b1;
        step();
        qif.flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        rst_n            = 1'b0;
        qif.flush        = 1'b0;
        qif.enq_valid    = 1'b0;
        qif.enq_instr    = '0;
        qif.enq_instr_no = '0;
        qif.reg_ready    = '1;
        qif.exu_ready    = '0;

        tbl[0]  = '{6'b000000, 5'd1,  1'b0};
        tbl[1]  = '{6'b001000, 5'd2,  1'b0};
        tbl[2]  = '{6'b001001, 5'd3,  1'b0};
        tbl[3]  = '{6'b000110, 5'd4,  1'b0};
        tbl[4]  = '{6'b001011, 5'd5,  1'b0};
        tbl[5]  = '{6'b001100, 5'd6,  1'b0};
        tbl[6]  = '{6'b001101, 5'd7,  1'b0};
        tbl[7]  = '{6'b001110, 5'd8,  1'b0};
        tbl[8]  = '{6'b001111, 5'd9,  1'b0};
        tbl[9]  = '{6'b101011, 5'd10, 1'b0};
        tbl[10] = '{6'b100011, 5'd11, 1'b0};
        tbl[11] = '{6'b000010, 5'd11, 1'b1};
        tbl[12] = '{6'b111111, 5'd11, 1'b1};
        tbl[13] = '{6'b000100, 5'd11, 1'b1};

        #3;
        check("rst_enq_ready", 64'(qif.enq_ready), 64'd0);
        check("rst_count", 64'(qif.count), 64'd0);
        check("rst_iss_valid", 64'(qif.iss_valid), 64'd0);
        check("rst_err", 64'(qif.err_unsupported), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_enq_ready", 64'(qif.enq_ready), 64'd1);

        // Opcode table: nothing issues while every lane is blocked.
        step();
        for (int i = 0; i < 14; i++) begin
            enq(mk(tbl[i].op, 5'd1, 5'd2, 5'd3), 32'(i));
            check($sformatf("tbl%0d_count", i), 64'(qif.count), 64'(tbl[i].exp_count));
            check($sformatf("tbl%0d_err", i), 64'(qif.err_unsupported), 64'(tbl[i].exp_err));
        end
        do_flush();
        check("tbl_flush_count", 64'(qif.count), 64'd0);
        check("tbl_flush_err", 64'(qif.err_unsupported), 64'd1);

        // Asynchronous reset with five entries in flight.
        for (int i = 0; i < 5; i++) enq(mk(6'b000000, 5'd1, 5'd2, 5'd3), 32'h100 + 32'(i));
        check("pre_rst_count", 64'(qif.count), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 64'(qif.count), 64'd0);
        check("mid_rst_iss_valid", 64'(qif.iss_valid), 64'd0);
        check("mid_rst_enq_ready", 64'(qif.enq_ready), 64'd0);
        check("mid_rst_err", 64'(qif.err_unsupported), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rel_enq_ready", 64'(qif.enq_ready), 64'd1);
        step();

        // Fill to DEPTH; the extra offer is refused.
        qif.reg_ready    = '0;
        qif.enq_instr    = mk(6'b000000, 5'd1, 5'd2, 5'd3);
        qif.enq_valid    = 1'b1;
        repeat (DEPTH) step();
        check("fill_count", 64'(qif.count), 64'd16);
        check("fill_enq_ready", 64'(qif.enq_ready), 64'd0);
        step();
        qif.enq_valid = 1'b0;
        check("fill_17th_count", 64'(qif.count), 64'd16);
        do_flush();
        check("fill_flush_count", 64'(qif.count), 64'd0);

        // Dual issue, oldest on lane 0.
        qif.reg_ready = '1;
        enq(mk(6'b000000, 5'd1, 5'd2, 5'd3), 32'h10);
        enq(mk(6'b000000, 5'd1, 5'd2, 5'd3), 32'h11);
        qif.exu_ready = 2'b11;
        step();
        check("dual_valid", 64'(qif.iss_valid), 64'b11);
        check("dual_lane0_no", 64'(lane_no(0)), 64'h10);
        check("dual_lane1_no", 64'(lane_no(1)), 64'h11);
        check("dual_lane0_instr", 64'(qif.iss_instr[IW-1:0]), 64'(mk(6'b000000, 5'd1, 5'd2, 5'd3)));
        check("dual_count", 64'(qif.count), 64'd0);
        qif.exu_ready = 2'b00;
        step();
        check("pulse_valid", 64'(qif.iss_valid), 64'b00);
        check("hold_lane0_no", 64'(lane_no(0)), 64'h10);

        // A freshly enqueued entry waits one cycle before it can issue.
        qif.exu_ready = 2'b11;
        enq(mk(6'b001101, 5'd1, 5'd4, 5'd0), 32'h12);
        check("fresh_valid", 64'(qif.iss_valid), 64'b00);
        check("fresh_count", 64'(qif.count), 64'd1);
        step();
        check("fresh_next_valid", 64'(qif.iss_valid), 64'b01);
        check("fresh_next_no", 64'(lane_no(0)), 64'h12);
        check("fresh_next_count", 64'(qif.count), 64'd0);

        // Issue and enqueue in the same cycle.
        qif.exu_ready = 2'b00;
        enq(mk(6'b000000, 5'd1, 5'd2, 5'd3), 32'h30);
        enq(mk(6'b000000, 5'd1, 5'd2, 5'd3), 32'h31);
        qif.exu_ready = 2'b01;
        enq(mk(6'b000000, 5'd1, 5'd2, 5'd3), 32'h32);
        check("simul_count", 64'(qif.count), 64'd2);
        check("simul_valid", 64'(qif.iss_valid), 64'b01);
        check("simul_lane0_no", 64'(lane_no(0)), 64'h30);
        qif.exu_ready = 2'b00;
        do_flush();

        // Full queue issuing two: no same-cycle space is offered.
        for (int i = 0; i < DEPTH; i++) enq(mk(6'b000000, 5'd1, 5'd2, 5'd3), 32'h40 + 32'(i));
        qif.enq_valid = 1'b1;
        qif.exu_ready = 2'b11;
        #1;
        check("full_issue_enq_ready", 64'(qif.enq_ready), 64'd0);
        step();
        qif.enq_valid = 1'b0;
        qif.exu_ready = 2'b00;
        check("full_issue_count", 64'(qif.count), 64'd14);
        check("full_issue_lane1_no", 64'(lane_no(1)), 64'h41);
        do_flush();

        // Younger ready entry bypasses an older blocked one, lane 0 masked.
        qif.reg_ready    = '1;
        qif.reg_ready[5] = 1'b0;
        enq(mk(6'b000000, 5'd5, 5'd2, 5'd3), 32'h20);
        enq(mk(6'b001101, 5'd1, 5'd4, 5'd0), 32'h21);
        qif.exu_ready = 2'b10;
        step();
        check("byp_valid", 64'(qif.iss_valid), 64'b10);
        check("byp_lane1_no", 64'(lane_no(1)), 64'h21);
        check("byp_count", 64'(qif.count), 64'd1);
        qif.reg_ready[5] = 1'b1;
        qif.exu_ready    = 2'b11;
        step();
        check("byp2_valid", 64'(qif.iss_valid), 64'b01);
        check("byp2_lane0_no", 64'(lane_no(0)), 64'h20);
        check("byp2_count", 64'(qif.count), 64'd0);

        // Unsupported opcode is dropped, then flush beats issue and enqueue.
        qif.exu_ready = 2'b00;
        enq(mk(6'b000010, 5'd1, 5'd2, 5'd3), 32'h50);
        check("unsup_err", 64'(qif.err_unsupported), 64'd1);
        check("unsup_count", 64'(qif.count), 64'd0);
        for (int i = 1; i <= 3; i++) enq(mk(6'b001000, 5'd1, 5'd2, 5'd0), 32'h50 + 32'(i));
        check("pre_flush_count", 64'(qif.count), 64'd3);
        qif.flush     = 1'b1;
        qif.exu_ready = 2'b11;
        enq(mk(6'b001000, 5'd1, 5'd2, 5'd0), 32'h54);
        qif.flush = 1'b0;
        check("flush_count", 64'(qif.count), 64'd0);
        check("flush_valid", 64'(qif.iss_valid), 64'b00);
        check("flush_err_kept", 64'(qif.err_unsupported), 64'd1);
        step();
        check("post_flush_count", 64'(qif.count), 64'd0);
        check("post_flush_valid", 64'(qif.iss_valid), 64'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
